// File: rtl/blocking_nonblocking_pair_if.sv
// rtl/blocking_nonblocking_pair_if.sv - data/result bundle for blocking_nonblocking_pair (mismatch under BLK_NBLK_CMP_EN)
interface blocking_nonblocking_pair_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b_blk;
    logic [WIDTH-1:0] c_blk;
    logic [WIDTH-1:0] b_nblk;
    logic [WIDTH-1:0] c_nblk;
    logic             vld_blk;
    logic             vld_nblk;
`ifdef BLK_NBLK_CMP_EN
    logic             mismatch;

    modport master (
        output a,
        input  b_blk, c_blk, b_nblk, c_nblk, vld_blk, vld_nblk, mismatch
    );
    modport slave (
        input  a,
        output b_blk, c_blk, b_nblk, c_nblk, vld_blk, vld_nblk, mismatch
    );
`else
    modport master (
        output a,
        input  b_blk, c_blk, b_nblk, c_nblk, vld_blk, vld_nblk
    );
    modport slave (
        input  a,
        output b_blk, c_blk, b_nblk, c_nblk, vld_blk, vld_nblk
    );
`endif
endinterface

// File: rtl/blocking_nonblocking_pair.sv
// rtl/blocking_nonblocking_pair.sv - collapsed vs. two-stage register pair; optional compare flag under BLK_NBLK_CMP_EN
module blocking_nonblocking_pair #(
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    blocking_nonblocking_pair_if.slave bus
);
    logic [WIDTH-1:0] b_blk_q;
    logic [WIDTH-1:0] c_blk_q;
    logic [WIDTH-1:0] b_nblk_q;
    logic [WIDTH-1:0] c_nblk_q;
    logic             vld_blk_q;
    logic             vld_nblk_q;

    // "b = a; c = b;" collapses to both registers loading a on the same edge,
    // so c_blk is written straight from a rather than from b_blk_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_blk_q <= '0;
            c_blk_q <= '0;
        end else begin
            b_blk_q <= bus.a;
            c_blk_q <= bus.a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_nblk_q <= '0;
            c_nblk_q <= '0;
        end else begin
            b_nblk_q <= bus.a;
            c_nblk_q <= b_nblk_q;
        end
    end

    // vld_nblk trails vld_blk by one edge, matching the extra stage on c_nblk.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_blk_q  <= 1'b0;
            vld_nblk_q <= 1'b0;
        end else begin
            vld_blk_q  <= 1'b1;
            vld_nblk_q <= vld_blk_q;
        end
    end

    assign bus.b_blk    = b_blk_q;
    assign bus.c_blk    = c_blk_q;
    assign bus.b_nblk   = b_nblk_q;
    assign bus.c_nblk   = c_nblk_q;
    assign bus.vld_blk  = vld_blk_q;
    assign bus.vld_nblk = vld_nblk_q;

`ifdef BLK_NBLK_CMP_EN
    logic mismatch_q;

    // Compares the values the two c registers are about to take:
    // next c_blk is a, next c_nblk is b_nblk, next vld_nblk is vld_blk.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= vld_blk_q && (bus.a != b_nblk_q);
        end
    end

    assign bus.mismatch = mismatch_q;
`endif
endmodule

// File: tb/tb_blocking_nonblocking_pair.sv
// tb/tb_blocking_nonblocking_pair.sv - randomized check of blocking_nonblocking_pair at WIDTH 4 and 8
module tb_blocking_nonblocking_pair;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    blocking_nonblocking_pair_if #(.WIDTH(4)) bus4 ();
    blocking_nonblocking_pair_if #(.WIDTH(8)) bus8 ();

    blocking_nonblocking_pair #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );
    blocking_nonblocking_pair #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    // samples accepted since the last reset edge, oldest first
    logic [7:0] hist4[$];
    logic [7:0] hist8[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [7:0] newest(input logic [7:0] h[$]);
        return (h.size() >= 1) ? h[h.size()-1] : 8'h00;
    endfunction

    function automatic logic [7:0] previous(input logic [7:0] h[$]);
        return (h.size() >= 2) ? h[h.size()-2] : 8'h00;
    endfunction

    task automatic step(input logic rst_v, input logic [3:0] a4, input logic [7:0] a8);
        rst      = rst_v;
        bus4.a   = a4;
        bus8.a   = a8;
        @(posedge clk);
        #1;
        if (rst_v) begin
            hist4.delete();
            hist8.delete();
        end else begin
            hist4.push_back({4'h0, a4});
            hist8.push_back(a8);
        end

        check("w4.b_blk",   {28'h0, bus4.b_blk},  {24'h0, newest(hist4)});
        check("w4.c_blk",   {28'h0, bus4.c_blk},  {24'h0, newest(hist4)});
        check("w4.b_nblk",  {28'h0, bus4.b_nblk}, {24'h0, newest(hist4)});
        check("w4.c_nblk",  {28'h0, bus4.c_nblk}, {24'h0, previous(hist4)});
        check("w4.vld_blk", {31'h0, bus4.vld_blk},  {31'h0, hist4.size() >= 1});
        check("w4.vld_nblk",{31'h0, bus4.vld_nblk}, {31'h0, hist4.size() >= 2});
        check("w8.c_blk",   {24'h0, bus8.c_blk},  {24'h0, newest(hist8)});
        check("w8.b_nblk",  {24'h0, bus8.b_nblk}, {24'h0, newest(hist8)});
        check("w8.c_nblk",  {24'h0, bus8.c_nblk}, {24'h0, previous(hist8)});
        check("w8.vld_nblk",{31'h0, bus8.vld_nblk}, {31'h0, hist8.size() >= 2});
`ifdef BLK_NBLK_CMP_EN
        check("w4.mismatch", {31'h0, bus4.mismatch},
              {31'h0, (hist4.size() >= 2) && (newest(hist4) != previous(hist4))});
        check("w8.mismatch", {31'h0, bus8.mismatch},
              {31'h0, (hist8.size() >= 2) && (newest(hist8) != previous(hist8))});
`endif
    endtask

    initial begin
        bus4.a = '0;
        bus8.a = '0;

        step(1'b1, 4'h0, 8'h00);
        step(1'b0, 4'h3, 8'hA5);
        step(1'b0, 4'h7, 8'h5A);
        step(1'b0, 4'hF, 8'hFF);
        step(1'b0, 4'hA, 8'h00);
        step(1'b0, 4'h2, 8'h80);
        step(1'b0, 4'h5, 8'h01);
        step(1'b0, 4'h5, 8'h01);
        step(1'b0, 4'h5, 8'h01);
        step(1'b0, 4'h7, 8'h7E);
        step(1'b0, 4'hF, 8'hE7);
        step(1'b1, 4'h9, 8'h99);
        step(1'b0, 4'hA, 8'hAA);
        step(1'b0, 4'hA, 8'hAA);

        for (int i = 0; i < 400; i++) begin
            logic       r;
            logic [3:0] v4;
            logic [7:0] v8;
            r  = ($urandom_range(0, 24) == 0);
            v4 = ($urandom_range(0, 3) == 0) ? bus4.a : 4'($urandom);
            v8 = ($urandom_range(0, 3) == 0) ? bus8.a : 8'($urandom);
            step(r, v4, v8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
